// File: rtl/mem_sys_pkg.sv
// Shared constants for the memory/peripheral subsystem: I/O address map,
// UART status bit positions and TX state encodings.
package mem_sys_pkg;

  localparam logic [15:0] IO_BASE          = 16'h8000;
  localparam logic [15:0] UART_DATA_ADDR   = IO_BASE;
  localparam logic [15:0] UART_STATUS_ADDR = IO_BASE + 16'h0004;
  localparam logic [15:0] CYCLES_ADDR      = IO_BASE + 16'h0008;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_LEVEL_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // The status register has only a 4-bit level field.
  function automatic logic [3:0] sat_level(input logic [7:0] level);
    return (level > 8'd15) ? 4'hF : level[3:0];
  endfunction

endpackage

// File: rtl/mem_sys_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser with a sticky
// overflow flag for pushes that arrive while the FIFO is full.
module mem_sys_uart_tx
  import mem_sys_pkg::*;
#(
  parameter int   UART_DIV   = 104,
  parameter int   FIFO_DEPTH = 8,
  localparam int  AW         = $clog2(FIFO_DEPTH),
  localparam int  LW         = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          clr_overflow_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o,
  output logic          overflow_o,
  output logic          tx_o
);

  localparam int            DW       = $clog2(UART_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(UART_DIV - 1);

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          ovf_q;

  tx_state_e     state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          pop, push_ok, div_last, tx;

  assign full_o     = (count_q == LW'(FIFO_DEPTH));
  assign empty_o    = (count_q == '0);
  assign level_o    = count_q;
  assign overflow_o = ovf_q;
  assign tx_o       = tx;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push_i && (!full_o || pop);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    tx       = 1'b1;
    div_last = (div_q == DIV_LAST);
    case (state_q)
      TX_IDLE: begin
        if (!empty_o) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          div_d   = '0;
          bit_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx    = 1'b0;
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) state_d = TX_DATA;
      end
      TX_DATA: begin
        tx    = shift_q[0];
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        if (div_last) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= TX_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + LW'(push_ok) - LW'(pop);
      if (push_i && !push_ok) ovf_q <= 1'b1;
      else if (clr_overflow_i) ovf_q <= 1'b0;
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_sys.sv
// Bus slave below the cpu memory port: byte-maskable word RAM, UART TX
// registers and a free-running cycle counter behind a one-cycle read return.
module mem_sys
  import mem_sys_pkg::*;
#(
  parameter int RAM_WORDS  = 4096,
  parameter int UART_DIV   = 104,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ren,
  input  logic [15:0] addr,
  output logic [31:0] rdata,
  output logic        rd_valid,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        uart_tx
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    ram_q [RAM_WORDS];
  logic [31:0]    rdata_q, rdata_d, io_rdata, cycle_q;
  logic           rd_valid_q;
  logic           ram_hit, rd_accept;
  logic [RAW-1:0] ram_idx;
  logic           fifo_full, fifo_empty, fifo_ovf;
  logic [LW-1:0]  fifo_level;

  assign ram_hit   = (32'(addr[15:2]) < 32'(RAM_WORDS));
  assign ram_idx   = addr[RAW+1:2];
  // A write wins over a simultaneous read; the read is simply dropped.
  assign rd_accept = ren && !wen;
  assign rdata     = rdata_q;
  assign rd_valid  = rd_valid_q;

  always_comb begin
    io_rdata = '0;
    if (addr == UART_STATUS_ADDR) begin
      io_rdata[STAT_FULL_BIT]             = fifo_full;
      io_rdata[STAT_EMPTY_BIT]            = fifo_empty;
      io_rdata[STAT_OVF_BIT]              = fifo_ovf;
      io_rdata[STAT_LEVEL_LSB +: 4]       = sat_level(8'(fifo_level));
    end else if (addr == CYCLES_ADDR) begin
      io_rdata = cycle_q;
    end
  end

  assign rdata_d = ram_hit ? ram_q[ram_idx] : io_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      cycle_q    <= cycle_q + 32'd1;
      rd_valid_q <= rd_accept;
      if (rd_accept) rdata_q <= rdata_d;
    end
  end

  // wmask bit 3 owns the low byte; the mask is big-endian relative to wdata.
  always_ff @(posedge clk) begin
    if (wen && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[3-b]) ram_q[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  mem_sys_uart_tx #(
    .UART_DIV   (UART_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_uart_tx (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_i         (wen && (addr == UART_DATA_ADDR) && wmask[3]),
    .push_data_i    (wdata[7:0]),
    .clr_overflow_i (rd_accept && (addr == UART_STATUS_ADDR)),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .level_o        (fifo_level),
    .overflow_o     (fifo_ovf),
    .tx_o           (uart_tx)
  );

endmodule
